// File: rtl/tap_bram_arbiter.sv
// tap_bram_arbiter
// Shares one single-port tap-coefficient BRAM between the host configuration
// path (port 0) and the FIR engine (port 1). Grants are combinational in the
// issue cycle, responses come back one cycle later, and accesses past the
// last valid word are flagged instead of touching memory. A clear sequencer
// can zero every valid word while holding off both requesters.
module tap_bram_arbiter #(
  parameter int DEPTH     = 11,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0,
  input  logic [DATA_W/8-1:0]   we0,
  input  logic [ADDR_W-1:0]     addr0,
  input  logic [DATA_W-1:0]     wdata0,
  output logic                  gnt0,
  output logic                  ack0,
  output logic [DATA_W-1:0]     rdata0,
  output logic                  err0,
  input  logic                  req1,
  input  logic [DATA_W/8-1:0]   we1,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [DATA_W-1:0]     wdata1,
  output logic                  gnt1,
  output logic                  ack1,
  output logic [DATA_W-1:0]     rdata1,
  output logic                  err1,
  input  logic                  clr_start,
  output logic                  clr_done,
  output logic                  busy,
  output logic                  bram_EN,
  output logic [DATA_W/8-1:0]   bram_WE,
  output logic [ADDR_W-1:0]     bram_A,
  output logic [DATA_W-1:0]     bram_Di,
  input  logic [DATA_W-1:0]     bram_Do
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    w_cnt_nxt;
  logic                r_last;        // 1: port 1 was granted most recently
  logic [ADDR_W-1:0]   r_a_last;      // address held on the BRAM when idle
  logic                r_ack0;
  logic                r_ack1;
  logic                r_err0;
  logic                r_err1;
  logic                r_rd0;         // ack carries BRAM read data
  logic                r_rd1;
  logic                r_clr_done;

  logic                w_oob0;
  logic                w_oob1;
  logic                w_pick1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_clr_done_nxt;
  logic [NB-1:0]       w_we;
  logic [ADDR_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_di;

  assign w_oob0 = (addr0[ADDR_W-1:2] >= DEPTH_IDX);
  assign w_oob1 = (addr1[ADDR_W-1:2] >= DEPTH_IDX);

  // Arbitration, BRAM drive and clear-sequencer next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_clr_done_nxt = 1'b0;
    w_pick1        = 1'b0;
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
    w_we           = {NB{1'b0}};
    w_a            = r_a_last;
    w_di           = {DATA_W{1'b0}};
    if (RST) begin
      w_state_nxt = ST_ARB;
      w_cnt_nxt   = {IDX_W{1'b0}};
      w_a         = {ADDR_W{1'b0}};
    end else begin
      case (r_state)
        ST_ARB: begin
          if (clr_start) begin
            // Clear wins over any request; nobody is granted this cycle.
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = {IDX_W{1'b0}};
          end else begin
            if (PRIO_MODE != 0) begin
              w_pick1 = req1 & ~req0;
            end else begin
              // On a tie, hand the slot to the port not served last.
              w_pick1 = req1 & (~req0 | ~r_last);
            end
            w_gnt1 = req1 & w_pick1;
            w_gnt0 = req0 & ~w_pick1;
            if (w_gnt0) begin
              w_we = w_oob0 ? {NB{1'b0}} : we0;
              w_a  = w_oob0 ? {ADDR_W{1'b0}} : addr0;
              w_di = wdata0;
            end else if (w_gnt1) begin
              w_we = w_oob1 ? {NB{1'b0}} : we1;
              w_a  = w_oob1 ? {ADDR_W{1'b0}} : addr1;
              w_di = wdata1;
            end else begin
              w_we = {NB{1'b0}};
            end
          end
        end
        ST_CLEAR: begin
          w_we = {NB{1'b1}};
          w_a  = {r_cnt, 2'b00};
          w_di = {DATA_W{1'b0}};
          if (r_cnt == LAST_IDX) begin
            w_state_nxt    = ST_ARB;
            w_clr_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          w_state_nxt = ST_ARB;
        end
      endcase
    end
  end

  // State, round-robin pointer, held address and registered responses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_ARB;
      r_cnt      <= {IDX_W{1'b0}};
      r_last     <= 1'b1;
      r_a_last   <= {ADDR_W{1'b0}};
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_rd0      <= 1'b0;
      r_rd1      <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_a_last   <= w_a;
      if (w_gnt0) begin
        r_last <= 1'b0;
      end else if (w_gnt1) begin
        r_last <= 1'b1;
      end else begin
        r_last <= r_last;
      end
      r_ack0     <= w_gnt0;
      r_ack1     <= w_gnt1;
      r_err0     <= w_gnt0 & w_oob0;
      r_err1     <= w_gnt1 & w_oob1;
      r_rd0      <= w_gnt0 & ~w_oob0 & (we0 == {NB{1'b0}});
      r_rd1      <= w_gnt1 & ~w_oob1 & (we1 == {NB{1'b0}});
      r_clr_done <= w_clr_done_nxt;
    end
  end

  // BRAM read data is only valid in the ack cycle, so it is steered, not stored.
  assign rdata0   = r_rd0 ? bram_Do : {DATA_W{1'b0}};
  assign rdata1   = r_rd1 ? bram_Do : {DATA_W{1'b0}};
  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign err0     = r_err0;
  assign err1     = r_err1;
  assign clr_done = r_clr_done;
  assign busy     = (r_state == ST_CLEAR);
  // The BRAM output is gated by an unregistered enable, so keep it on outside reset.
  assign bram_EN  = ~RST;
  assign bram_WE  = w_we;
  assign bram_A   = w_a;
  assign bram_Di  = w_di;

endmodule

// File: tb/tb_tap_bram_arbiter.sv
// Bench for tap_bram_arbiter: a behavioural BRAM, a reference memory and a
// per-cycle response scoreboard, plus directed checks on grants and clears.
module tb_tap_bram_arbiter;

  localparam int DEPTH = 11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0, req1, clr_start;
  logic [3:0]  we0, we1;
  logic [11:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, ack0, ack1, err0, err1, clr_done, busy;
  logic [31:0] rdata0, rdata1;
  logic        bram_EN;
  logic [3:0]  bram_WE;
  logic [11:0] bram_A;
  logic [31:0] bram_Di, bram_Do;

  logic        fp_gnt0, fp_gnt1, fp_ack0, fp_ack1, fp_err0, fp_err1;
  logic        fp_clr_done, fp_busy, fp_EN;
  logic [31:0] fp_rdata0, fp_rdata1, fp_Di;
  logic [3:0]  fp_WE;
  logic [11:0] fp_A;

  always #5 CLK = ~CLK;

  tap_bram_arbiter #(.DEPTH(DEPTH), .ADDR_W(12), .DATA_W(32), .PRIO_MODE(0)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
    .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_A(bram_A),
    .bram_Di(bram_Di), .bram_Do(bram_Do)
  );

  tap_bram_arbiter #(.DEPTH(DEPTH), .ADDR_W(12), .DATA_W(32), .PRIO_MODE(1)) dut_fp (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(fp_gnt0), .ack0(fp_ack0), .rdata0(fp_rdata0), .err0(fp_err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(fp_gnt1), .ack1(fp_ack1), .rdata1(fp_rdata1), .err1(fp_err1),
    .clr_start(clr_start), .clr_done(fp_clr_done), .busy(fp_busy),
    .bram_EN(fp_EN), .bram_WE(fp_WE), .bram_A(fp_A),
    .bram_Di(fp_Di), .bram_Do(32'h0000_0000)
  );

  // Behavioural single-port BRAM: registered address, output gated by EN.
  logic [31:0] mem [0:1023];
  logic [9:0]  ra;
  logic        mem_ready = 1'b0;
  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      ra        <= 10'h000;
      mem_ready <= 1'b1;
    end else if (bram_EN) begin
      for (int b = 0; b < 4; b++)
        if (bram_WE[b]) mem[bram_A[11:2]][8*b +: 8] <= bram_Di[8*b +: 8];
      ra <= bram_A[11:2];
    end
  end
  assign bram_Do = bram_EN ? mem[ra] : 32'h0000_0000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference memory and response scoreboard.
  typedef struct packed {
    logic        a0;
    logic        e0;
    logic [31:0] d0;
    logic        a1;
    logic        e1;
    logic [31:0] d1;
  } resp_t;

  resp_t       sb_q[$];
  logic [31:0] ref_mem [0:15];
  logic        ref_ready = 1'b0;
  int          zap_seq = 0;
  int          zap_cnt = 0;
  int          zap_seen = 0;

  task automatic model_access(input logic [3:0] we, input logic [11:0] a, input logic [31:0] wd,
                              output logic e, output logic [31:0] d);
    logic [9:0] idx;
    idx = a[11:2];
    e   = (idx >= 10'(DEPTH));
    d   = 32'h0;
    if (!e) begin
      if (we == 4'h0) d = ref_mem[idx];
      else
        for (int b = 0; b < 4; b++)
          if (we[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  always @(negedge CLK) begin
    resp_t e;
    resp_t n;
    if (!ref_ready) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
      ref_ready = 1'b1;
    end
    if (zap_seen != zap_seq) begin
      for (int i = 0; i < zap_cnt; i++) ref_mem[i] = 32'h0;
      zap_seen = zap_seq;
    end
    if (RST) begin
      sb_q.delete();
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val("ack_err", {28'h0, ack0, err0, ack1, err1}, {28'h0, e.a0, e.e0, e.a1, e.e1});
        check_val("rdata0", rdata0, e.d0);
        check_val("rdata1", rdata1, e.d1);
      end
      check_val("gnt_excl", {31'h0, gnt0 & gnt1}, 32'h0);
      n = '0;
      if (gnt0) begin
        n.a0 = 1'b1;
        model_access(we0, addr0, wdata0, n.e0, n.d0);
      end
      if (gnt1) begin
        n.a1 = 1'b1;
        model_access(we1, addr1, wdata1, n.e1, n.d1);
      end
      sb_q.push_back(n);
    end
  end

  task automatic access(input int p, input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
    logic oob;
    oob = (a[11:2] >= 10'(DEPTH));
    if (p == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
    @(negedge CLK);
    check_val("gnt", {30'h0, gnt1, gnt0}, (p == 0) ? 32'h1 : 32'h2);
    check_val("bram_WE", {28'h0, bram_WE}, oob ? 32'h0 : {28'h0, we});
    check_val("bram_A", {20'h0, bram_A}, oob ? 32'h0 : {20'h0, a});
    if (!oob) check_val("bram_Di", bram_Di, d);
    @(posedge CLK); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; req0 = 1'b0; req1 = 1'b0; clr_start = 1'b0;
    we0 = 4'h0; we1 = 4'h0; addr0 = 12'h0; addr1 = 12'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_gnt", {30'h0, gnt1, gnt0}, 32'h0);
    check_val("rst_ack", {28'h0, ack0, err0, ack1, err1}, 32'h0);
    check_val("rst_rdata", rdata0 | rdata1, 32'h0);
    check_val("rst_bram", {15'h0, bram_EN, bram_WE, bram_A}, 32'h0);
    check_val("rst_di", bram_Di, 32'h0);
    check_val("rst_busy", {30'h0, busy, clr_done}, 32'h0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check_val("en_on", {31'h0, bram_EN}, 32'h1);
    step();

    // Both ports request together: alternate (RR) / port 0 only (fixed).
    req0 = 1'b1; we0 = 4'h0; addr0 = 12'h008;
    req1 = 1'b1; we1 = 4'h0; addr1 = 12'h00C;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check_val("rr_gnt", {30'h0, gnt1, gnt0}, (k % 2 == 0) ? 32'h1 : 32'h2);
      check_val("fp_gnt", {30'h0, fp_gnt1, fp_gnt0}, 32'h1);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Write then read back, back to back.
    access(0, 4'hF, 12'h008, 32'hDEAD_BEEF);
    access(0, 4'h0, 12'h008, 32'h0);
    step();

    // Out-of-range and last valid word.
    access(1, 4'h0, 12'h02C, 32'h0);
    access(0, 4'hF, 12'h02C, 32'h1234_5678);
    access(1, 4'hF, 12'h028, 32'hCAFE_F00D);
    access(1, 4'h0, 12'h028, 32'h0);

    // Partial byte-lane write.
    access(0, 4'hF, 12'h00C, 32'h0000_0000);
    access(0, 4'h5, 12'h00C, 32'hFFFF_FFFF);
    access(1, 4'h0, 12'h00C, 32'h0);
    @(negedge CLK);
    check_val("idle_hold_A", {20'h0, bram_A}, 32'h0000_000C);
    check_val("idle_WE", {28'h0, bram_WE}, 32'h0);
    step();

    // Fill, then clear with port 0 requesting.
    for (int k = 0; k < DEPTH; k++)
      access(0, 4'hF, 12'(k << 2), 32'h1000_0000 + 32'(k) * 32'h0101);
    access(0, 4'h0, 12'h010, 32'h0);
    clr_start = 1'b1; req0 = 1'b1; we0 = 4'h0; addr0 = 12'h008;
    zap_cnt = DEPTH; zap_seq++;
    @(negedge CLK);
    check_val("clr_start_gnt", {30'h0, gnt1, gnt0}, 32'h0);
    step();
    clr_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 3) clr_start = 1'b1;
      @(negedge CLK);
      check_val("clr_gnt", {30'h0, gnt1, gnt0}, 32'h0);
      check_val("clr_busy", {30'h0, busy, clr_done}, 32'h2);
      check_val("clr_WE", {28'h0, bram_WE}, 32'hF);
      check_val("clr_A", {20'h0, bram_A}, 32'(k << 2));
      check_val("clr_Di", bram_Di, 32'h0);
      step();
      clr_start = 1'b0;
    end
    @(negedge CLK);
    check_val("clr_done", {29'h0, busy, clr_done, gnt0}, 32'h3);
    step();
    req0 = 1'b0;
    @(negedge CLK);
    check_val("clr_done_pulse", {31'h0, clr_done}, 32'h0);
    step();
    for (int k = 0; k < DEPTH; k++) access(0, 4'h0, 12'(k << 2), 32'h0);

    // Fill, start a clear, reset in clear cycle 5.
    for (int k = 0; k < DEPTH; k++)
      access(1, 4'hF, 12'(k << 2), 32'h2000_0000 + 32'(k));
    clr_start = 1'b1; zap_cnt = 5; zap_seq++;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check_val("abort_busy", {30'h0, busy, clr_done}, 32'h2);
      step();
    end
    RST = 1'b1;
    @(negedge CLK);
    check_val("abort_rst_bram", {27'h0, bram_EN, bram_WE}, 32'h0);
    step();
    RST = 1'b0;
    for (int k = 0; k < 13; k++) begin
      @(negedge CLK);
      check_val("abort_no_done", {30'h0, busy, clr_done}, 32'h0);
      step();
    end
    for (int k = 0; k < DEPTH; k++) access(0, 4'h0, 12'(k << 2), 32'h0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
